scan_mux: RTL and testbench

- Parametrised, registered N-channel multiplexer. Successor to the 4:1 combinational mux.
- Selects one of CHANNELS input words of WIDTH bits and delivers it through an output register with a valid/ready handshake.
- Two modes: direct select by `sel`, or round-robin auto-scan over channels presenting valid data.
- Sits between multiple producers and a single downstream consumer.

---
 rtl/scan_mux.sv | 109 ++++++++++
 tb/tb_scan_mux.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/scan_mux.sv
// Registered N:1 channel mux, direct-select or round-robin scan; 1 cycle ch_valid&ch_ack -> q_valid.
// Backpressure: q/q_ch/q_valid hold and ch_ack stays low while q_valid && !q_ready; a drain and reload can share one edge.
module scan_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [CHANNELS-1:0]       ch_valid,
  output logic [CHANNELS-1:0]       ch_ack,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  output logic [WIDTH-1:0]          q,
  output logic [SELW-1:0]           q_ch,
  output logic                      q_valid,
  input  logic                      q_ready
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic             vld_q, vld_d;

  logic             load_ok;
  logic             grant;
  logic [SELW-1:0]  g;
  logic             hi_found, lo_found;
  logic [SELW-1:0]  hi_g, lo_g;

  always_comb begin
    load_ok  = !vld_q || q_ready;

    // Lowest valid channel at/above ptr wins; otherwise wrap to the lowest valid overall.
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_g     = '0;
    lo_g     = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (ch_valid[i]) begin
        lo_found = 1'b1;
        lo_g     = SELW'(i);
        if (SELW'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_g     = SELW'(i);
        end
      end
    end

    grant = 1'b0;
    g     = '0;
    if (mode) begin
      grant = lo_found;
      g     = hi_found ? hi_g : lo_g;
    end else begin
      // Only indices below CHANNELS can match, so out-of-range sel grants nothing.
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel == SELW'(i) && ch_valid[i]) begin
          grant = 1'b1;
          g     = sel;
        end
      end
    end
    grant = grant && load_ok && !rst;

    ch_ack = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant && g == SELW'(i)) ch_ack[i] = 1'b1;
    end

    data_d = data_q;
    ch_d   = ch_q;
    vld_d  = vld_q;
    ptr_d  = ptr_q;
    if (load_ok) begin
      vld_d = grant;
      if (grant) begin
        ch_d = g;
        for (int i = 0; i < CHANNELS; i++) begin
          if (g == SELW'(i)) data_d = din[i*WIDTH +: WIDTH];
        end
      end
    end
    // Pointer wraps at CHANNELS, not at 2^SELW.
    if (grant && mode) begin
      ptr_d = (g == SELW'(CHANNELS - 1)) ? '0 : g + SELW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      ch_q   <= '0;
      vld_q  <= 1'b0;
      ptr_q  <= '0;
    end else begin
      data_q <= data_d;
      ch_q   <= ch_d;
      vld_q  <= vld_d;
      ptr_q  <= ptr_d;
    end
  end

  assign q       = data_q;
  assign q_ch    = ch_q;
  assign q_valid = vld_q;

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: a 4-channel and a 3-channel instance share stimulus;
// expected words are queued when an ack is expected and popped when q_valid is due.
module tb_scan_mux;

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic [3:0]  ch_valid;
  logic        mode;
  logic [1:0]  sel;
  logic        q_ready;

  logic [3:0]  ack4;
  logic [7:0]  q4;
  logic [1:0]  q_ch4;
  logic        q_valid4;
  logic [2:0]  ack3;
  logic [7:0]  q3;
  logic [1:0]  q_ch3;
  logic        q_valid3;

  bit          dut3;
  int          vectors;
  int          miscompares;
  logic [9:0]  sbq[$];
  logic [9:0]  cur;
  logic        mvld;

  logic [3:0]  obs_ack;
  logic [7:0]  obs_q;
  logic [1:0]  obs_ch;
  logic        obs_vld;

  assign obs_ack = dut3 ? {1'b0, ack3} : ack4;
  assign obs_q   = dut3 ? q3 : q4;
  assign obs_ch  = dut3 ? q_ch3 : q_ch4;
  assign obs_vld = dut3 ? q_valid3 : q_valid4;

  scan_mux #(.WIDTH(8), .CHANNELS(4), .SELW(2)) u_mux4 (
    .clk(clk), .rst(rst), .din(din), .ch_valid(ch_valid), .ch_ack(ack4),
    .mode(mode), .sel(sel), .q(q4), .q_ch(q_ch4), .q_valid(q_valid4), .q_ready(q_ready)
  );

  scan_mux #(.WIDTH(8), .CHANNELS(3), .SELW(2)) u_mux3 (
    .clk(clk), .rst(rst), .din(din[23:0]), .ch_valid(ch_valid[2:0]), .ch_ack(ack3),
    .mode(mode), .sel(sel), .q(q3), .q_ch(q_ch3), .q_valid(q_valid3), .q_ready(q_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are already set; check ack now, then outputs just after the edge.
  task automatic step(input logic [3:0] exp_ack);
    logic exp_qv;
    int   idx;
    #1;
    chk("ch_ack", obs_ack, exp_ack);
    exp_qv = (exp_ack != 4'b0) || (mvld && !q_ready);
    if (exp_ack != 4'b0) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (exp_ack[i]) idx = i;
      sbq.push_back({idx[1:0], din[idx*8 +: 8]});
    end
    @(posedge clk);
    #1;
    chk("q_valid", obs_vld, exp_qv);
    if (exp_ack != 4'b0 && sbq.size() > 0) cur = sbq.pop_front();
    if (exp_qv) begin
      chk("q", obs_q, cur[7:0]);
      chk("q_ch", obs_ch, cur[9:8]);
    end
    mvld = exp_qv;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_q_valid", obs_vld, 1'b0);
    chk("rst_q", obs_q, 8'h00);
    chk("rst_q_ch", obs_ch, 2'd0);
    chk("rst_ch_ack", obs_ack, 4'b0);
    @(negedge clk);
    rst  = 1'b0;
    mvld = 1'b0;
    sbq.delete();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    dut3        = 1'b0;
    mvld        = 1'b0;
    cur         = '0;
    rst         = 1'b1;
    din         = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    ch_valid    = 4'b1111;
    mode        = 1'b0;
    sel         = 2'd2;
    q_ready     = 1'b1;
    @(negedge clk);
    do_reset();

    // Direct select
    sel = 2'd2; ch_valid = 4'b1111; step(4'b0100);
    sel = 2'd3; ch_valid = 4'b0111; step(4'b0000);
    sel = 2'd0;                     step(4'b0001);

    // Round-robin fairness from reset
    do_reset();
    mode = 1'b1; ch_valid = 4'b1011;
    for (int r = 0; r < 2; r++) begin
      step(4'b0001);
      step(4'b0010);
      step(4'b1000);
    end

    // Reset mid-run while q_valid is high
    @(posedge clk);
    #1;
    chk("pre_rst_q_valid", obs_vld, 1'b1);
    @(negedge clk);
    do_reset();

    // Backpressure
    ch_valid = 4'b1111; q_ready = 1'b1;
    step(4'b0001);
    q_ready = 1'b0;
    step(4'b0000);
    step(4'b0000);
    step(4'b0000);
    q_ready = 1'b1;
    step(4'b0010);
    step(4'b0100);
    step(4'b1000);

    // Mode switch keeps the scan pointer
    do_reset();
    mode = 1'b1; ch_valid = 4'b1111;
    step(4'b0001);
    step(4'b0010);
    mode = 1'b0; sel = 2'd0;
    step(4'b0001);
    step(4'b0001);
    mode = 1'b1;
    step(4'b0100);

    // Three-channel instance: wrap at 3, sel=3 out of range
    dut3 = 1'b1;
    do_reset();
    mode = 1'b1; ch_valid = 4'b1111;
    step(4'b0001);
    step(4'b0010);
    step(4'b0100);
    step(4'b0001);
    mode = 1'b0; sel = 2'd3;
    step(4'b0000);
    sel = 2'd2;
    step(4'b0100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
